// File: rtl/uart_device_tx_pkg.sv
// Shared types and constants for the device-side UART transmit driver.
//   parity_mode_e : encoding of the parity_mode input (3 also means none)
//   tx_state_e    : transmit FSM states
package uart_device_tx_pkg;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    EVEN = 2'd1,
    ODD  = 2'd2
  } parity_mode_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  localparam logic UART_TX_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO with registered occupancy count and full/empty flags.
//   clk, rst    : clock, synchronous active-high reset
//   push        : write push_data (caller guarantees !full)
//   pop         : advance read pointer (caller guarantees !empty)
//   pop_data_c  : head entry, combinational read
//   count       : occupied entries
//   full, empty : registered status flags
module uart_tx_fifo
  import uart_device_tx_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data_c,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_next_c;

  assign count_next_c = count + CNT_W'(push) - CNT_W'(pop);
  assign pop_data_c   = mem[rd_ptr];

  // Storage array carries no reset; stale entries are never read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count_next_c;
      full  <= (count_next_c == CNT_W'(DEPTH));
      empty <= (count_next_c == '0);
    end
  end

endmodule

// File: rtl/uart_device_tx_driver.sv
// UART transmit engine: buffers proxy words in a FIFO and serialises them
// on tx as start / data (LSB first) / optional parity / 1-2 stop bits.
//   clk, rst     : clock, synchronous active-high reset
//   baud_div     : cycles per serial bit (0 behaves as 1), latched per frame
//   parity_mode  : 0/3 none, 1 even, 2 odd, latched per frame
//   stop_bits    : 0 one stop bit, 1 two, latched per frame
//   wr_valid/wr_data/wr_ready : proxy write handshake
//   tx           : registered serial output, idles high
//   busy         : frame in flight or FIFO non-empty
//   fifo_count   : occupied FIFO entries
module uart_device_tx_driver
  import uart_device_tx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DIV_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DIV_WIDTH-1:0]          baud_div,
  input  logic [1:0]                    parity_mode,
  input  logic                          stop_bits,
  input  logic                          wr_valid,
  input  logic [DATA_WIDTH-1:0]         wr_data,
  output logic                          wr_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned BIT_W = $clog2(DATA_WIDTH + 1);

  tx_state_e               state;
  logic [DIV_WIDTH-1:0]    div_cnt;
  logic [DIV_WIDTH-1:0]    cfg_div_m1;
  logic [BIT_W-1:0]        bit_cnt;
  logic [DATA_WIDTH-1:0]   shift;
  logic                    par_acc;
  logic                    cfg_par_en;
  logic                    cfg_odd;
  logic                    cfg_two_stop;

  logic                    fifo_full;
  logic                    fifo_empty;
  logic [DATA_WIDTH-1:0]   fifo_data_c;

  logic                    push_c;
  logic                    pop_c;
  logic                    last_div_c;
  logic                    last_data_c;
  logic                    last_stop_c;
  logic [DIV_WIDTH-1:0]    eff_div_c;
  logic [CNT_W-1:0]        count_next_c;
  parity_mode_e            pmode_c;

  assign wr_ready     = !fifo_full;
  assign push_c       = wr_valid && !fifo_full;
  assign last_div_c   = (div_cnt == '0);
  assign last_data_c  = (bit_cnt == BIT_W'(DATA_WIDTH - 1));
  assign last_stop_c  = (bit_cnt == BIT_W'(cfg_two_stop));
  assign eff_div_c    = (baud_div == '0) ? DIV_WIDTH'(1) : baud_div;
  assign pmode_c      = parity_mode_e'(parity_mode);
  assign count_next_c = fifo_count + CNT_W'(push_c) - CNT_W'(pop_c);

  // Pop from IDLE, or on the final STOP cycle to chain frames without a gap.
  assign pop_c = !fifo_empty &&
                 ((state == IDLE) ||
                  ((state == STOP) && last_div_c && last_stop_c));

  uart_tx_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push_c),
    .push_data  (wr_data),
    .pop        (pop_c),
    .pop_data_c (fifo_data_c),
    .count      (fifo_count),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  // FSM, divider, bit counter, shifter and parity. tx follows state by one
  // cycle, so every bit on the line still lasts exactly one divisor period.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      div_cnt      <= '0;
      cfg_div_m1   <= '0;
      bit_cnt      <= '0;
      shift        <= '0;
      par_acc      <= 1'b0;
      cfg_par_en   <= 1'b0;
      cfg_odd      <= 1'b0;
      cfg_two_stop <= 1'b0;
      tx           <= UART_TX_IDLE_LEVEL;
      busy         <= 1'b0;
    end else begin
      busy <= (state != IDLE) || pop_c || (count_next_c != '0);

      case (state)
        START:   tx <= 1'b0;
        DATA:    tx <= shift[0];
        PARITY:  tx <= par_acc ^ cfg_odd;
        default: tx <= UART_TX_IDLE_LEVEL;
      endcase

      if (pop_c) begin
        cfg_div_m1   <= eff_div_c - 1'b1;
        cfg_par_en   <= (pmode_c == EVEN) || (pmode_c == ODD);
        cfg_odd      <= (pmode_c == ODD);
        cfg_two_stop <= stop_bits;
        div_cnt      <= eff_div_c - 1'b1;
        shift        <= fifo_data_c;
        par_acc      <= 1'b0;
        bit_cnt      <= '0;
        state        <= START;
      end else if (state != IDLE) begin
        if (!last_div_c) begin
          div_cnt <= div_cnt - 1'b1;
        end else begin
          div_cnt <= cfg_div_m1;
          case (state)
            START: begin
              bit_cnt <= '0;
              state   <= DATA;
            end
            DATA: begin
              par_acc <= par_acc ^ shift[0];
              shift   <= shift >> 1;
              if (last_data_c) begin
                bit_cnt <= '0;
                state   <= cfg_par_en ? PARITY : STOP;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
            PARITY: begin
              bit_cnt <= '0;
              state   <= STOP;
            end
            STOP: begin
              if (last_stop_c) begin
                state <= IDLE;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_device_tx_driver.sv
// Directed self-checking bench for uart_device_tx_driver (8 data bits, depth 4).
module tb_uart_device_tx_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] baud_div = 16'd4;
  logic [1:0]  parity_mode = 2'd0;
  logic        stop_bits = 1'b0;
  logic        wr_valid = 1'b0;
  logic [7:0]  wr_data = 8'h00;
  logic        wr_ready;
  logic        tx;
  logic        busy;
  logic [2:0]  fifo_count;

  int errors = 0;
  int checks = 0;

  uart_device_tx_driver #(
    .DATA_WIDTH (8),
    .FIFO_DEPTH (4),
    .DIV_WIDTH  (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .baud_div    (baud_div),
    .parity_mode (parity_mode),
    .stop_bits   (stop_bits),
    .wr_valid    (wr_valid),
    .wr_data     (wr_data),
    .wr_ready    (wr_ready),
    .tx          (tx),
    .busy        (busy),
    .fifo_count  (fifo_count)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  // Checks one frame on tx; entered at the negedge of its first line cycle.
  task automatic expect_frame(input logic [7:0] data, input int div,
                              input int pm, input bit two, input string name);
    logic bits[$];
    int   eff;
    logic par;
    eff = (div == 0) ? 1 : div;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(data[i]);
    if (pm == 1 || pm == 2) begin
      par = ^data;
      if (pm == 2) par = ~par;
      bits.push_back(par);
    end
    bits.push_back(1'b1);
    if (two) bits.push_back(1'b1);
    for (int b = 0; b < int'(bits.size()); b++) begin
      for (int c = 0; c < eff; c++) begin
        if (!(b == 0 && c == 0)) @(negedge clk);
        checks++;
        if (tx !== bits[b]) begin
          errors++;
          $display("FAIL %s bit%0d cyc%0d: tx=%b expected %b", name, b, c, tx, bits[b]);
        end
      end
    end
  endtask

  // One word into an idle DUT: latency checks, full frame, then idle again.
  task automatic single_frame(input logic [7:0] data, input int div,
                              input int pm, input bit two, input string name);
    baud_div    = 16'(div);
    parity_mode = 2'(pm);
    stop_bits   = two;
    wr_valid    = 1'b1;
    wr_data     = data;
    @(posedge clk);
    @(negedge clk);
    wr_valid = 1'b0;
    checks++;
    if (fifo_count !== 3'd1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL %s_accept: count=%0d busy=%b expected count=1 busy=1", name, fifo_count, busy);
    end
    @(negedge clk);
    checks++;
    if (tx !== 1'b1) begin
      errors++;
      $display("FAIL %s_pop_cycle: tx=%b expected 1", name, tx);
    end
    @(negedge clk);
    expect_frame(data, div, pm, two, name);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || tx !== 1'b1 || fifo_count !== 3'd0) begin
      errors++;
      $display("FAIL %s_end: busy=%b tx=%b count=%0d expected busy=0 tx=1 count=0",
               name, busy, tx, fifo_count);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (tx !== 1'b1 || wr_ready !== 1'b1 || busy !== 1'b0 || fifo_count !== 3'd0) begin
      errors++;
      $display("FAIL reset: tx=%b wr_ready=%b busy=%b count=%0d expected 1 1 0 0",
               tx, wr_ready, busy, fifo_count);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    single_frame(8'hA5, 4, 0, 1'b0, "basic");
  endtask

  task automatic test_parity();
    single_frame(8'hA5, 4, 1, 1'b0, "even_1stop");
    single_frame(8'hA5, 4, 2, 1'b1, "odd_2stop");
    single_frame(8'h6B, 2, 3, 1'b0, "mode3_none");
  endtask

  task automatic test_back_to_back();
    baud_div = 16'd4; parity_mode = 2'd0; stop_bits = 1'b0;
    wr_valid = 1'b1; wr_data = 8'h01;
    @(posedge clk); @(negedge clk);
    checks++;
    if (fifo_count !== 3'd1) begin
      errors++; $display("FAIL b2b_count0: count=%0d expected 1", fifo_count);
    end
    wr_data = 8'h02;
    @(posedge clk); @(negedge clk);
    checks++;
    if (fifo_count !== 3'd1) begin
      errors++; $display("FAIL b2b_count1: count=%0d expected 1", fifo_count);
    end
    wr_data = 8'h03;
    @(posedge clk); @(negedge clk);
    wr_valid = 1'b0;
    checks++;
    if (fifo_count !== 3'd2) begin
      errors++; $display("FAIL b2b_count2: count=%0d expected 2", fifo_count);
    end
    expect_frame(8'h01, 4, 0, 1'b0, "b2b_f1");
    checks++;
    if (fifo_count !== 3'd1) begin
      errors++; $display("FAIL b2b_count3: count=%0d expected 1", fifo_count);
    end
    @(negedge clk);
    expect_frame(8'h02, 4, 0, 1'b0, "b2b_f2");
    checks++;
    if (fifo_count !== 3'd0) begin
      errors++; $display("FAIL b2b_count4: count=%0d expected 0", fifo_count);
    end
    @(negedge clk);
    expect_frame(8'h03, 4, 0, 1'b0, "b2b_f3");
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL b2b_busy_end: busy=%b expected 0", busy);
    end
  endtask

  task automatic test_fifo_full();
    logic [7:0] words [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    baud_div = 16'd8; parity_mode = 2'd0; stop_bits = 1'b0;
    fork
      begin
        int   n;
        int   guard;
        logic acc;
        n = 0;
        guard = 0;
        while (n < 6 && guard < 500) begin
          wr_valid = 1'b1;
          wr_data  = words[n];
          acc      = wr_ready;
          @(posedge clk);
          @(negedge clk);
          if (acc) begin
            n++;
            if (n == 5) begin
              checks++;
              if (wr_ready !== 1'b0 || fifo_count !== 3'd4) begin
                errors++;
                $display("FAIL full_flag: wr_ready=%b count=%0d expected 0 4", wr_ready, fifo_count);
              end
            end
          end
          guard++;
        end
        wr_valid = 1'b0;
        checks++;
        if (n != 6) begin
          errors++;
          $display("FAIL full_accepts: accepted=%0d expected 6", n);
        end
      end
      begin
        repeat (3) @(negedge clk);
        for (int k = 0; k < 6; k++) begin
          if (k > 0) @(negedge clk);
          expect_frame(words[k], 8, 0, 1'b0, $sformatf("full_w%0d", k));
        end
      end
    join
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || fifo_count !== 3'd0) begin
      errors++;
      $display("FAIL full_end: busy=%b count=%0d expected 0 0", busy, fifo_count);
    end
  endtask

  task automatic test_config_change();
    baud_div = 16'd4; parity_mode = 2'd0; stop_bits = 1'b0;
    wr_valid = 1'b1; wr_data = 8'hC3;
    @(posedge clk); @(negedge clk);
    wr_data = 8'h3C;
    @(posedge clk); @(negedge clk);
    wr_valid = 1'b0;
    baud_div = 16'd2;
    @(negedge clk);
    expect_frame(8'hC3, 4, 0, 1'b0, "cfg_f1");
    @(negedge clk);
    expect_frame(8'h3C, 2, 0, 1'b0, "cfg_f2");
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL cfg_end: busy=%b expected 0", busy);
    end
  endtask

  task automatic test_reset_mid_frame();
    baud_div = 16'd4; parity_mode = 2'd0; stop_bits = 1'b0;
    wr_valid = 1'b1; wr_data = 8'hA5;
    @(posedge clk); @(negedge clk);
    wr_data = 8'h0F;
    @(posedge clk); @(negedge clk);
    wr_valid = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    checks++;
    if (tx !== 1'b1 || fifo_count !== 3'd0 || busy !== 1'b0 || wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst: tx=%b count=%0d busy=%b wr_ready=%b expected 1 0 0 1",
               tx, fifo_count, busy, wr_ready);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midrst_quiet: tx=%b busy=%b expected 1 0", tx, busy);
    end
    single_frame(8'h96, 4, 0, 1'b0, "after_rst");
  endtask

  task automatic test_div_zero();
    single_frame(8'h5A, 0, 0, 1'b0, "div0");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_back_to_back();
    test_fifo_full();
    test_config_change();
    test_reset_mid_frame();
    test_div_zero();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
